// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared definitions for the two-requester memory arbiter:
//           FSM state encoding, requester index constants and a small
//           index-to-one-hot helper.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Requester indices as seen on the two-bit request/response vectors.
    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return (idx == REQ_LOADER) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way round-robin winner selection. A lone requester always
//           wins; on a tie the requester that was not granted last wins.
// Ports   : req  [1:0] in   request vector
//           last       in   index of the most recently granted requester
//           gnt  [1:0] out  one-hot (or zero) grant
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Requester 0 wins unless requester 1 also asks and 0 was granted last.
    assign gnt[0] = req[0] & (~req[1] | (last == REQ_LOADER));
    assign gnt[1] = req[1] & (~req[0] | (last == REQ_CORE));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Arbitrates two requesters (core, loader/debug) onto a single-port
//           memory with a one-cycle read latency. One transfer is in flight at
//           a time: IDLE accepts, ACCESS strobes the memory, RESP returns read
//           data to the owning requester.
// Ports   : clk, rst                   clock, synchronous active-high reset
//           rq_valid/rq_we [1:0]       per-requester request and access type
//           rq_addr0/1, rq_wdata0/1    per-requester address and write data
//           rq_ready [1:0]             acceptance, combinational in IDLE only
//           rs_valid [1:0], rs_rdata   one-cycle read response
//           mem_addr, mem_wdata        registered memory address/write data
//           mem_we, mem_re             one-cycle memory strobes
//           mem_rdata                  memory read data (one cycle after re)
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rq_valid,
    input  logic [1:0]        rq_we,
    input  logic [ADDR_W-1:0] rq_addr0,
    input  logic [ADDR_W-1:0] rq_addr1,
    input  logic [DATA_W-1:0] rq_wdata0,
    input  logic [DATA_W-1:0] rq_wdata1,
    output logic [1:0]        rq_ready,
    output logic [1:0]        rs_valid,
    output logic [DATA_W-1:0] rs_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic                r_idx;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [1:0]          w_gnt;
    logic                w_win_idx;
    logic                w_accept;

    rr_arbiter2 u_rr (
        .req  (rq_valid),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    assign w_win_idx = w_gnt[1];
    assign w_accept  = (r_state == ST_IDLE) && (w_gnt != 2'b00);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = r_we ? ST_IDLE : ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Everything is held low while rst is high so that a reset landing in
    // ACCESS or RESP never leaks a strobe or a response pulse.
    always_comb begin
        rq_ready = 2'b00;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        rs_valid = 2'b00;
        if (!rst) begin
            case (r_state)
                ST_IDLE: rq_ready = w_gnt;
                ST_ACCESS: begin
                    mem_we = r_we;
                    mem_re = ~r_we;
                end
                ST_RESP:   rs_valid = idx_to_onehot(r_idx);
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    // Captured only at acceptance, so request inputs are don't-care while a
    // transfer is in flight and the memory bus holds its last value in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_LOADER;
            r_idx        <= REQ_CORE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_win_idx;
            r_idx        <= w_win_idx;
            r_we         <= rq_we[w_win_idx];
            r_addr       <= w_win_idx ? rq_addr1  : rq_addr0;
            r_wdata      <= w_win_idx ? rq_wdata1 : rq_wdata0;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rs_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter. Directed stimulus pushes the
//           expected memory strobes and read responses (with their cycle
//           stamps) into queues; a monitor pops and compares whenever the
//           DUT presents a strobe or a response.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_we;
    logic [31:0] rq_addr0, rq_addr1;
    logic [31:0] rq_wdata0, rq_wdata1;
    logic [1:0]  rq_ready;
    logic [1:0]  rs_valid;
    logic [31:0] rs_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_ev_t;

    typedef struct {
        int          cyc;
        logic [1:0]  v;
        logic [31:0] d;
    } rs_ev_t;

    mem_ev_t mem_q[$];
    rs_ev_t  rs_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rq_valid  (rq_valid),
        .rq_we     (rq_we),
        .rq_addr0  (rq_addr0),
        .rq_addr1  (rq_addr1),
        .rq_wdata0 (rq_wdata0),
        .rq_wdata1 (rq_wdata1),
        .rq_ready  (rq_ready),
        .rs_valid  (rs_valid),
        .rs_rdata  (rs_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h4) ? 32'h12345678 : (a ^ 32'h5A5A0000);
    endfunction

    // Memory model: data valid the cycle after mem_re, garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_re ? mem_fn(mem_addr) : 32'hBADBAD00;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always begin : mon
        mem_ev_t me;
        rs_ev_t  re;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (mem_we || mem_re) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_strobe", {62'd0, mem_we, mem_re}, 64'd0);
                end else begin
                    me = mem_q.pop_front();
                    chk("mem_cycle",  64'(cyc), 64'(me.cyc));
                    chk("mem_strobe", {62'd0, mem_we, mem_re}, me.we ? 64'd2 : 64'd1);
                    chk("mem_addr",   {32'd0, mem_addr}, {32'd0, me.addr});
                    if (me.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, me.wdata});
                end
            end
            if (rs_valid != 2'b00) begin
                if (rs_q.size() == 0) begin
                    chk("unexpected_rs_valid", {62'd0, rs_valid}, 64'd0);
                end else begin
                    re = rs_q.pop_front();
                    chk("rs_cycle", 64'(cyc), 64'(re.cyc));
                    chk("rs_valid", {62'd0, rs_valid}, {62'd0, re.v});
                    chk("rs_rdata", {32'd0, rs_rdata}, {32'd0, re.d});
                end
            end
        end
    end

    task automatic push_mem(input int c, input logic we, input logic [31:0] a, input logic [31:0] wd);
        mem_ev_t e;
        e.cyc = c; e.we = we; e.addr = a; e.wdata = wd;
        mem_q.push_back(e);
    endtask

    task automatic push_rs(input int c, input logic [1:0] v, input logic [31:0] d);
        rs_ev_t e;
        e.cyc = c; e.v = v; e.d = d;
        rs_q.push_back(e);
    endtask

    // One uncontended transfer from requester idx; returns in its last busy cycle.
    task automatic do_single(input int idx, input logic we, input logic [31:0] a,
                             input logic [31:0] wd);
        logic [1:0] oh;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        if (idx == 0) begin rq_addr0 = a; rq_wdata0 = wd; end
        else          begin rq_addr1 = a; rq_wdata1 = wd; end
        rq_we    = we ? 2'b11 : 2'b00;
        rq_valid = oh;
        #1 chk("single_ready", {62'd0, rq_ready}, {62'd0, oh});
        push_mem(cyc + 1, we, a, wd);
        if (!we) push_rs(cyc + 2, oh, mem_fn(a));
        @(negedge clk);
        #1 chk("access_ready", {62'd0, rq_ready}, 64'd0);
        rq_valid = 2'b00;
        if (!we) begin
            @(negedge clk);
            #1 chk("resp_ready", {62'd0, rq_ready}, 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rq_valid = 2'b11; rq_we = 2'b00;
        rq_addr0 = '0; rq_addr1 = '0; rq_wdata0 = '0; rq_wdata1 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready",   {62'd0, rq_ready}, 64'd0);
        chk("rst_strobes", {62'd0, mem_we, mem_re}, 64'd0);
        chk("rst_rs_valid", {62'd0, rs_valid}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        rst = 1'b0;
        rq_valid = 2'b00;

        // Single write from the core, then a single read from the loader.
        do_single(0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_single(1, 1'b0, 32'h04, 32'h0);

        // Contention: both write continuously; grants must alternate 0,1,0,1.
        rq_we = 2'b11;
        rq_addr0 = 32'h1; rq_wdata0 = 32'hA0A0A0A0;
        rq_addr1 = 32'h2; rq_wdata1 = 32'hB1B1B1B1;
        rq_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("rr_ready", {62'd0, rq_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
            if (i % 2 == 0) push_mem(cyc + 1, 1'b1, 32'h1, 32'hA0A0A0A0);
            else            push_mem(cyc + 1, 1'b1, 32'h2, 32'hB1B1B1B1);
            @(negedge clk);
            #1 chk("rr_busy_ready", {62'd0, rq_ready}, 64'd0);
        end
        @(negedge clk);
        rq_valid = 2'b00;

        // Core read aborted by reset in its ACCESS cycle; next tie goes to core.
        @(negedge clk);
        rq_we = 2'b00; rq_addr0 = 32'h40; rq_valid = 2'b01;
        #1 chk("abort_accept", {62'd0, rq_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b1; rq_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        rq_we = 2'b11;
        rq_addr0 = 32'h50; rq_wdata0 = 32'h55555555;
        rq_addr1 = 32'h60; rq_wdata1 = 32'h66666666;
        rq_valid = 2'b11;
        #1;
        chk("abort_no_rs_valid", {62'd0, rs_valid}, 64'd0);
        chk("abort_no_strobe",   {62'd0, mem_we, mem_re}, 64'd0);
        chk("post_rst_tie",      {62'd0, rq_ready}, 64'd1);
        push_mem(cyc + 1, 1'b1, 32'h50, 32'h55555555);
        @(negedge clk);
        rq_valid = 2'b00;

        // Request inputs changed after acceptance must not reach the memory.
        @(negedge clk);
        rq_we = 2'b01; rq_addr0 = 32'h20; rq_wdata0 = 32'h20202020; rq_valid = 2'b01;
        #1 chk("late_accept", {62'd0, rq_ready}, 64'd1);
        push_mem(cyc + 1, 1'b1, 32'h20, 32'h20202020);
        @(negedge clk);
        rq_addr0 = 32'h30; rq_wdata0 = 32'h30303030; rq_valid = 2'b00;
        #1 chk("late_mem_addr", {32'd0, mem_addr}, 64'h20);

        // Idle for 10 cycles: no strobes, no responses, bus holds last value.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle_outputs", {59'd0, mem_we, mem_re, rs_valid, 1'b0}, 64'd0);
        end
        chk("idle_addr_hold",  {32'd0, mem_addr},  64'h20);
        chk("idle_wdata_hold", {32'd0, mem_wdata}, 64'h20202020);

        repeat (2) @(negedge clk);
        #3;
        chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
        chk("rs_q_drained",  64'(rs_q.size()),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
